// File: rtl/wb_intercon_np.sv
// Single-master, N-slave Wishbone classic interconnect with registered decode,
// bus error on unmapped addresses or slave watchdog timeout, and fault address capture.
module wb_intercon_np #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_ADDR =
    {32'h1000_0000, 32'hF000_0008, 32'hF000_0000, 32'h0000_1000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK =
    {32'hFFFF_F000, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'hFFFF_F000},
  parameter int TIMEOUT    = 255
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [ADDR_WIDTH-1:0]            wbm_adr_i,
  input  logic [DATA_WIDTH-1:0]            wbm_dat_i,
  output logic [DATA_WIDTH-1:0]            wbm_dat_o,
  input  logic [DATA_WIDTH/8-1:0]          wbm_sel_i,
  input  logic                             wbm_we_i,
  input  logic                             wbm_cyc_i,
  input  logic                             wbm_stb_i,
  output logic                             wbm_ack_o,
  output logic                             wbm_err_o,
  output logic [ADDR_WIDTH-1:0]            wbs_adr_o,
  output logic [DATA_WIDTH-1:0]            wbs_dat_o,
  output logic [DATA_WIDTH/8-1:0]          wbs_sel_o,
  output logic                             wbs_we_o,
  output logic [NUM_SLAVES-1:0]            wbs_cyc_o,
  output logic [NUM_SLAVES-1:0]            wbs_stb_o,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] wbs_dat_i,
  input  logic [NUM_SLAVES-1:0]            wbs_ack_i,
  input  logic [NUM_SLAVES-1:0]            wbs_err_i,
  output logic [ADDR_WIDTH-1:0]            err_adr_o
);

  localparam int WDOG_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

  state_t                  state, state_next;
  logic [NUM_SLAVES-1:0]   grant, grant_next;
  logic [WDOG_W-1:0]       wdog, wdog_next;
  logic [ADDR_WIDTH-1:0]   err_adr_next;
  logic [NUM_SLAVES-1:0]   hit_onehot;
  logic                    hit_any;
  logic                    slv_ack, slv_err;
  logic [DATA_WIDTH-1:0]   slv_dat;

  assign wbs_adr_o = wbm_adr_i;
  assign wbs_dat_o = wbm_dat_i;
  assign wbs_sel_o = wbm_sel_i;
  assign wbs_we_o  = wbm_we_i;

  // grant is only non-zero in BUSY, so it doubles as the per-slave cyc/stb
  assign wbs_cyc_o = grant;
  assign wbs_stb_o = grant;

  always_comb begin
    hit_any    = 1'b0;
    hit_onehot = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (!hit_any &&
          ((wbm_adr_i & SLAVE_MASK[k*ADDR_WIDTH +: ADDR_WIDTH]) ==
           (SLAVE_ADDR[k*ADDR_WIDTH +: ADDR_WIDTH] & SLAVE_MASK[k*ADDR_WIDTH +: ADDR_WIDTH]))) begin
        hit_any       = 1'b1;
        hit_onehot[k] = 1'b1;
      end
    end
  end

  always_comb begin
    slv_ack = |(wbs_ack_i & grant);
    slv_err = |(wbs_err_i & grant);
    slv_dat = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (grant[k]) slv_dat = slv_dat | wbs_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_next   = state;
    grant_next   = grant;
    wdog_next    = wdog;
    err_adr_next = err_adr_o;
    wbm_ack_o    = 1'b0;
    wbm_err_o    = 1'b0;
    wbm_dat_o    = '0;
    case (state)
      IDLE: begin
        if (wbm_cyc_i && wbm_stb_i) begin
          if (hit_any) begin
            grant_next = hit_onehot;
            wdog_next  = '0;
            state_next = BUSY;
          end else begin
            err_adr_next = wbm_adr_i;
            state_next   = ERR;
          end
        end
      end
      BUSY: begin
        wbm_dat_o = slv_dat;
        if (!wbm_cyc_i) begin
          grant_next = '0;
          state_next = IDLE;
        end else if (slv_err) begin
          wbm_err_o    = 1'b1;
          err_adr_next = wbm_adr_i;
          grant_next   = '0;
          state_next   = IDLE;
        end else if (slv_ack) begin
          wbm_ack_o  = 1'b1;
          grant_next = '0;
          state_next = IDLE;
        end else if (TIMEOUT != 0 && wdog == WDOG_LAST) begin
          wbm_err_o    = 1'b1;
          err_adr_next = wbm_adr_i;
          grant_next   = '0;
          state_next   = IDLE;
        end else if (wdog != '1) begin
          wdog_next = wdog + WDOG_W'(1);
        end
      end
      ERR: begin
        wbm_err_o  = 1'b1;
        state_next = IDLE;
      end
      default: begin
        grant_next = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      grant     <= '0;
      wdog      <= '0;
      err_adr_o <= '0;
    end else begin
      state     <= state_next;
      grant     <= grant_next;
      wdog      <= wdog_next;
      err_adr_o <= err_adr_next;
    end
  end

endmodule

// File: tb/tb_wb_intercon_np.sv
// Scoreboard-driven bench for wb_intercon_np with default slave map and an 8-cycle watchdog.
module tb_wb_intercon_np;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] wbm_adr_i;
  logic [15:0] wbm_dat_i;
  logic [15:0] wbm_dat_o;
  logic [1:0]  wbm_sel_i;
  logic        wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_ack_o, wbm_err_o;
  logic [31:0] wbs_adr_o;
  logic [15:0] wbs_dat_o;
  logic [1:0]  wbs_sel_o;
  logic        wbs_we_o;
  logic [3:0]  wbs_cyc_o, wbs_stb_o;
  logic [63:0] wbs_dat_i;
  logic [3:0]  wbs_ack_i, wbs_err_i;
  logic [31:0] err_adr_o;

  typedef struct {
    logic        is_err;
    logic [15:0] dat;
    logic [31:0] adr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_intercon_np #(.TIMEOUT(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_dat_o(wbm_dat_o),
    .wbm_sel_i(wbm_sel_i), .wbm_we_i(wbm_we_i), .wbm_cyc_i(wbm_cyc_i),
    .wbm_stb_i(wbm_stb_i), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_we_o(wbs_we_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
    .err_adr_o(err_adr_o)
  );

  task automatic idle_slaves();
    wbs_ack_i = '0;
    wbs_err_i = '0;
    for (int k = 0; k < 4; k++) wbs_dat_i[k*16 +: 16] = 16'(16'h1111 * (k + 1));
  endtask

  // Master + single responding slave; returns what the master saw. Bounded to 40 cycles.
  task automatic xfer(input logic [31:0] adr, input logic we, input logic [15:0] wdat,
                      input int idx, input int delay, input logic r_ack, input logic r_err,
                      input logic [15:0] rdat, input logic [3:0] noise_ack,
                      output logic got_ack, output logic got_err, output logic [15:0] got_dat,
                      output int stb_cycles, output logic [3:0] stb_seen,
                      output logic [3:0] cyc_first, output logic bcast_ok, output int n_cycles);
    wbm_adr_i = adr; wbm_we_i = we; wbm_dat_i = wdat; wbm_sel_i = 2'b11;
    wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
    wbs_ack_i = noise_ack;
    got_ack = 1'b0; got_err = 1'b0; got_dat = '0;
    stb_cycles = 0; stb_seen = '0; cyc_first = '0; bcast_ok = 1'b1; n_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_cycles = i + 1;
      if (i == 0) cyc_first = wbs_cyc_o;
      stb_seen = stb_seen | wbs_stb_o;
      if (idx >= 0 && wbs_stb_o[idx]) begin
        if (wbs_adr_o !== adr || wbs_dat_o !== wdat || wbs_we_o !== we || wbs_sel_o !== 2'b11)
          bcast_ok = 1'b0;
        if (stb_cycles == delay) begin
          if (r_ack) wbs_ack_i[idx] = 1'b1;
          if (r_err) wbs_err_i[idx] = 1'b1;
          wbs_dat_i[idx*16 +: 16] = rdat;
        end
        stb_cycles++;
      end
      #1;
      if (wbm_ack_o || wbm_err_o) begin
        got_ack = wbm_ack_o; got_err = wbm_err_o; got_dat = wbm_dat_o;
        break;
      end
    end
    @(posedge clk); #1;
    wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
    idle_slaves();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    wbm_adr_i = '0; wbm_dat_i = '0; wbm_sel_i = '0; wbm_we_i = 1'b0;
    wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
    idle_slaves();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({wbm_ack_o, wbm_err_o, wbs_cyc_o, wbs_stb_o} !== 10'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b want=0", {wbm_ack_o, wbm_err_o, wbs_cyc_o, wbs_stb_o});
    end
    checks++;
    if (wbm_dat_o !== 16'h0 || err_adr_o !== 32'h0) begin
      errors++; $display("FAIL reset_data dat=%h err_adr=%h want=0", wbm_dat_o, err_adr_o);
    end
    @(posedge clk); #1;
    rst_i = 1'b0;
  endtask

  task automatic test_read();
    logic a, e, bo; logic [15:0] d; logic [3:0] ss, cf; int sc, nc; exp_t x;
    sb.push_back('{is_err: 1'b0, dat: 16'hBEEF, adr: 32'h0});
    xfer(32'h0000_1004, 1'b0, 16'h0, 0, 2, 1'b1, 1'b0, 16'hBEEF, 4'h0, a, e, d, sc, ss, cf, bo, nc);
    checks++;
    if (!(a || e)) begin
      errors++; $display("FAIL read_resp got=none want=ack"); void'(sb.pop_front());
    end else begin
      x = sb.pop_front();
      if (a !== !x.is_err || e !== x.is_err || d !== x.dat) begin
        errors++; $display("FAIL read_data ack=%b err=%b dat=%h want ack dat=%h", a, e, d, x.dat);
      end
    end
    checks++;
    if (ss !== 4'b0001 || sc !== 3 || nc !== 4) begin
      errors++; $display("FAIL read_sel stb=%b stbcyc=%0d ncyc=%0d want 0001/3/4", ss, sc, nc);
    end
    @(negedge clk);
    checks++;
    if (wbs_cyc_o !== 4'b0 || wbm_ack_o !== 1'b0 || wbm_dat_o !== 16'h0) begin
      errors++; $display("FAIL read_idle cyc=%b ack=%b dat=%h want 0", wbs_cyc_o, wbm_ack_o, wbm_dat_o);
    end
  endtask

  task automatic test_write();
    logic a, e, bo; logic [15:0] d; logic [3:0] ss, cf; int sc, nc; exp_t x;
    sb.push_back('{is_err: 1'b0, dat: 16'h0, adr: 32'h0});
    xfer(32'hF000_000A, 1'b1, 16'h00A5, 2, 0, 1'b1, 1'b0, 16'h0, 4'h0, a, e, d, sc, ss, cf, bo, nc);
    checks++;
    if (!(a || e)) begin
      errors++; $display("FAIL write_resp got=none want=ack"); void'(sb.pop_front());
    end else begin
      x = sb.pop_front();
      if (a !== !x.is_err || e !== x.is_err) begin
        errors++; $display("FAIL write_resp ack=%b err=%b want ack", a, e);
      end
    end
    checks++;
    if (ss !== 4'b0100 || bo !== 1'b1) begin
      errors++; $display("FAIL write_sel stb=%b bcast=%b want 0100/1", ss, bo);
    end
  endtask

  task automatic test_unmapped();
    logic a, e, bo; logic [15:0] d; logic [3:0] ss, cf; int sc, nc; exp_t x;
    sb.push_back('{is_err: 1'b1, dat: 16'h0, adr: 32'h2000_0000});
    xfer(32'h2000_0000, 1'b0, 16'h0, -1, 0, 1'b0, 1'b0, 16'h0, 4'h0, a, e, d, sc, ss, cf, bo, nc);
    checks++;
    if (!(a || e)) begin
      errors++; $display("FAIL unmapped_resp got=none want=err"); void'(sb.pop_front());
    end else begin
      x = sb.pop_front();
      if (e !== x.is_err || a !== 1'b0 || err_adr_o !== x.adr) begin
        errors++; $display("FAIL unmapped_err err=%b ack=%b err_adr=%h want 1/0/%h", e, a, err_adr_o, x.adr);
      end
    end
    checks++;
    if (ss !== 4'b0 || nc !== 2) begin
      errors++; $display("FAIL unmapped_timing stb=%b ncyc=%0d want 0000/2", ss, nc);
    end
    @(negedge clk);
    checks++;
    if (wbm_err_o !== 1'b0) begin
      errors++; $display("FAIL unmapped_pulse err=%b want 0", wbm_err_o);
    end
  endtask

  task automatic test_timeout();
    logic a, e, bo; logic [15:0] d; logic [3:0] ss, cf; int sc, nc; exp_t x;
    sb.push_back('{is_err: 1'b1, dat: 16'h0, adr: 32'h1000_0010});
    xfer(32'h1000_0010, 1'b0, 16'h0, 3, 99, 1'b0, 1'b0, 16'h0, 4'h0, a, e, d, sc, ss, cf, bo, nc);
    checks++;
    if (!(a || e)) begin
      errors++; $display("FAIL timeout_resp got=none want=err"); void'(sb.pop_front());
    end else begin
      x = sb.pop_front();
      if (e !== x.is_err || err_adr_o !== x.adr) begin
        errors++; $display("FAIL timeout_err err=%b err_adr=%h want 1/%h", e, err_adr_o, x.adr);
      end
    end
    checks++;
    if (sc !== 8 || ss !== 4'b1000) begin
      errors++; $display("FAIL timeout_len busy=%0d stb=%b want 8/1000", sc, ss);
    end
    @(negedge clk);
    checks++;
    if (wbs_cyc_o[3] !== 1'b0 || wbm_err_o !== 1'b0) begin
      errors++; $display("FAIL timeout_release cyc3=%b err=%b want 0/0", wbs_cyc_o[3], wbm_err_o);
    end
  endtask

  task automatic test_ack_err();
    logic a, e, bo; logic [15:0] d; logic [3:0] ss, cf; int sc, nc; exp_t x;
    sb.push_back('{is_err: 1'b1, dat: 16'h0, adr: 32'hF000_0002});
    xfer(32'hF000_0002, 1'b0, 16'h0, 1, 1, 1'b1, 1'b1, 16'h1234, 4'h0, a, e, d, sc, ss, cf, bo, nc);
    checks++;
    if (!(a || e)) begin
      errors++; $display("FAIL ackerr_resp got=none want=err"); void'(sb.pop_front());
    end else begin
      x = sb.pop_front();
      if (e !== x.is_err || a !== 1'b0 || err_adr_o !== x.adr || ss !== 4'b0010) begin
        errors++; $display("FAIL ackerr_prio err=%b ack=%b err_adr=%h stb=%b want 1/0/%h/0010",
                           e, a, err_adr_o, ss, x.adr);
      end
    end
  endtask

  task automatic test_ignore_other();
    logic a, e, bo; logic [15:0] d; logic [3:0] ss, cf; int sc, nc; exp_t x;
    sb.push_back('{is_err: 1'b0, dat: 16'h5A5A, adr: 32'h0});
    xfer(32'hF000_0008, 1'b0, 16'h0, 2, 3, 1'b1, 1'b0, 16'h5A5A, 4'b0001, a, e, d, sc, ss, cf, bo, nc);
    checks++;
    if (!(a || e)) begin
      errors++; $display("FAIL ignore_resp got=none want=ack"); void'(sb.pop_front());
    end else begin
      x = sb.pop_front();
      if (a !== 1'b1 || d !== x.dat || sc !== 4) begin
        errors++; $display("FAIL ignore_other ack=%b dat=%h stbcyc=%0d want 1/%h/4", a, d, sc, x.dat);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic a, e, bo; logic [15:0] d; logic [3:0] ss, cf; int sc, nc; exp_t x;
    sb.push_back('{is_err: 1'b0, dat: 16'hC001, adr: 32'h0});
    sb.push_back('{is_err: 1'b0, dat: 16'hC003, adr: 32'h0});
    for (int t = 0; t < 2; t++) begin
      if (t == 0)
        xfer(32'h0000_1FFE, 1'b0, 16'h0, 0, 1, 1'b1, 1'b0, 16'hC001, 4'h0, a, e, d, sc, ss, cf, bo, nc);
      else
        xfer(32'h1000_0FFE, 1'b0, 16'h0, 3, 1, 1'b1, 1'b0, 16'hC003, 4'h0, a, e, d, sc, ss, cf, bo, nc);
      checks++;
      if (!(a || e)) begin
        errors++; $display("FAIL b2b_resp%0d got=none want=ack", t); void'(sb.pop_front());
      end else begin
        x = sb.pop_front();
        if (a !== 1'b1 || d !== x.dat || cf !== 4'b0 || nc !== 3) begin
          errors++; $display("FAIL b2b_xfer%0d ack=%b dat=%h cyc0=%b ncyc=%0d want 1/%h/0000/3",
                             t, a, d, cf, nc, x.dat);
        end
      end
    end
  endtask

  task automatic test_abort();
    bit seen = 1'b0;
    wbm_adr_i = 32'h0000_1000; wbm_we_i = 1'b0; wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = wbs_stb_o[0];
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL abort_grant got=no stb want=stb0");
    end
    wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
    wbs_ack_i[0] = 1'b1;
    #1;
    checks++;
    if (wbm_ack_o !== 1'b0 || wbm_err_o !== 1'b0) begin
      errors++; $display("FAIL abort_quiet ack=%b err=%b want 0/0", wbm_ack_o, wbm_err_o);
    end
    @(posedge clk); #1;
    idle_slaves();
    @(negedge clk);
    checks++;
    if (wbs_cyc_o !== 4'b0 || wbm_ack_o !== 1'b0 || wbm_err_o !== 1'b0 || err_adr_o !== 32'hF000_0002) begin
      errors++; $display("FAIL abort_idle cyc=%b ack=%b err=%b err_adr=%h want 0/0/0/f0000002",
                         wbs_cyc_o, wbm_ack_o, wbm_err_o, err_adr_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_busy();
    bit seen = 1'b0;
    wbm_adr_i = 32'h1000_0020; wbm_we_i = 1'b0; wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = wbs_cyc_o[3];
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL rstbusy_grant got=no cyc want=cyc3");
    end
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if (wbs_cyc_o !== 4'b0 || wbs_stb_o !== 4'b0 || err_adr_o !== 32'h0 || wbm_dat_o !== 16'h0) begin
      errors++; $display("FAIL rstbusy_async cyc=%b stb=%b err_adr=%h dat=%h want 0",
                         wbs_cyc_o, wbs_stb_o, err_adr_o, wbm_dat_o);
    end
    wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    checks++;
    if (wbs_cyc_o !== 4'b0 || wbm_ack_o !== 1'b0 || wbm_err_o !== 1'b0) begin
      errors++; $display("FAIL rstbusy_idle cyc=%b ack=%b err=%b want 0", wbs_cyc_o, wbm_ack_o, wbm_err_o);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_unmapped();
    test_timeout();
    test_ack_err();
    test_ignore_other();
    test_back_to_back();
    test_abort();
    test_reset_mid_busy();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
